// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer
// Turns the packet byte stream from the TX token/handshake builder into
// full-speed USB line states: SYNC, LSB-first data with bit stuffing and
// NRZI encoding, then EOP (SE0, SE0, J). One line bit per bit_en pulse.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   bit_en          : bit-time strobe; all line/FSM activity happens on it
//   tx_to_sop/eop   : first / last byte of packet markers
//   tx_to_valid     : byte available
//   tx_to_ready     : byte accepted when valid && ready
//   tx_to_data      : packet byte (PID first)
//   tx_dp, tx_dm    : D+/D- drive levels
//   tx_oe           : transceiver output enable
//   tx_busy         : packet in progress (SYNC through final J)
//   tx_underrun     : one-clk pulse when the next byte was not ready in time
module usb_tx_serializer #(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         STUFF_LEN    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic       tx_to_sop,
  input  logic       tx_to_eop,
  input  logic       tx_to_valid,
  output logic       tx_to_ready,
  input  logic [7:0] tx_to_data,
  output logic       tx_dp,
  output logic       tx_dm,
  output logic       tx_oe,
  output logic       tx_busy,
  output logic       tx_underrun
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
  localparam logic [OW-1:0] STUFF_PRE = OW'(STUFF_LEN - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      buf_data_reg, buf_data_next;
  logic            buf_eop_reg, buf_eop_next;
  logic            buf_valid_reg, buf_valid_next;
  logic [7:0]      shift_reg, shift_next;
  logic            shift_eop_reg, shift_eop_next;
  logic [2:0]      idx_reg, idx_next;
  logic [OW-1:0]   ones_reg, ones_next;
  logic            last_stuff_reg, last_stuff_next;
  logic            dp_reg, dp_next;
  logic            dm_reg, dm_next;
  logic            oe_reg, oe_next;
  logic            busy_reg, busy_next;
  logic            underrun_reg, underrun_next;

  logic            ready;
  logic            take;
  logic            emit;
  logic            emit_bit;

  assign ready = !buf_valid_reg && (state_reg != EOP_SE0) && (state_reg != EOP_J);
  assign take  = tx_to_valid && ready;

  always_comb begin
    state_next      = state_reg;
    buf_data_next   = buf_data_reg;
    buf_eop_next    = buf_eop_reg;
    buf_valid_next  = buf_valid_reg;
    shift_next      = shift_reg;
    shift_eop_next  = shift_eop_reg;
    idx_next        = idx_reg;
    ones_next       = ones_reg;
    last_stuff_next = last_stuff_reg;
    dp_next         = dp_reg;
    dm_next         = dm_reg;
    oe_next         = oe_reg;
    busy_next       = busy_reg;
    underrun_next   = 1'b0;
    emit            = 1'b0;
    emit_bit        = 1'b0;

    // Bytes without sop while idle are swallowed so the next packet starts cleanly.
    if (take && (state_reg != IDLE || tx_to_sop)) begin
      buf_data_next  = tx_to_data;
      buf_eop_next   = tx_to_eop;
      buf_valid_next = 1'b1;
    end

    if (bit_en) begin
      case (state_reg)
        IDLE: begin
          if (buf_valid_reg) begin
            emit       = 1'b1;
            emit_bit   = SYNC_PATTERN[0];
            idx_next   = 3'd1;
            oe_next    = 1'b1;
            busy_next  = 1'b1;
            state_next = SYNC;
          end
        end
        SYNC: begin
          emit     = 1'b1;
          emit_bit = SYNC_PATTERN[idx_reg];
          if (idx_reg == 3'd7) begin
            shift_next     = buf_data_reg;
            shift_eop_next = buf_eop_reg;
            buf_valid_next = 1'b0;
            idx_next       = 3'd0;
            state_next     = DATA;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
        DATA: begin
          emit = 1'b1;
          if (ones_reg == STUFF_MAX) begin
            // Stuff slot: a 0 that does not consume a data bit.
            emit_bit = 1'b0;
            if (last_stuff_reg) begin
              last_stuff_next = 1'b0;
              idx_next        = 3'd0;
              state_next      = EOP_SE0;
            end
          end else begin
            emit_bit = shift_reg[idx_reg];
            if (idx_reg == 3'd7) begin
              idx_next = 3'd0;
              if (shift_eop_reg) begin
                // A stuff bit owed after the final data bit still goes out before EOP.
                if (emit_bit && ones_reg == STUFF_PRE) begin
                  last_stuff_next = 1'b1;
                end else begin
                  state_next = EOP_SE0;
                end
              end else if (buf_valid_reg) begin
                shift_next     = buf_data_reg;
                shift_eop_next = buf_eop_reg;
                buf_valid_next = 1'b0;
              end else begin
                underrun_next = 1'b1;
                state_next    = EOP_SE0;
              end
            end else begin
              idx_next = idx_reg + 3'd1;
            end
          end
        end
        EOP_SE0: begin
          dp_next   = 1'b0;
          dm_next   = 1'b0;
          ones_next = '0;
          if (idx_reg == 3'd1) begin
            idx_next   = 3'd0;
            state_next = EOP_J;
          end else begin
            idx_next = 3'd1;
          end
        end
        EOP_J: begin
          // First strobe drives J; the following strobe releases the bus.
          if (idx_reg == 3'd0) begin
            dp_next  = 1'b1;
            dm_next  = 1'b0;
            idx_next = 3'd1;
          end else begin
            oe_next    = 1'b0;
            busy_next  = 1'b0;
            idx_next   = 3'd0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // NRZI: a 0 toggles J<->K, a 1 holds; the ones counter saturates.
    if (emit) begin
      if (emit_bit) begin
        ones_next = (ones_reg == STUFF_MAX) ? ones_reg : ones_reg + 1'b1;
      end else begin
        ones_next = '0;
        dp_next   = ~dp_reg;
        dm_next   = ~dm_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      buf_data_reg   <= '0;
      buf_eop_reg    <= 1'b0;
      buf_valid_reg  <= 1'b0;
      shift_reg      <= '0;
      shift_eop_reg  <= 1'b0;
      idx_reg        <= '0;
      ones_reg       <= '0;
      last_stuff_reg <= 1'b0;
      dp_reg         <= 1'b1;
      dm_reg         <= 1'b0;
      oe_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      buf_data_reg   <= buf_data_next;
      buf_eop_reg    <= buf_eop_next;
      buf_valid_reg  <= buf_valid_next;
      shift_reg      <= shift_next;
      shift_eop_reg  <= shift_eop_next;
      idx_reg        <= idx_next;
      ones_reg       <= ones_next;
      last_stuff_reg <= last_stuff_next;
      dp_reg         <= dp_next;
      dm_reg         <= dm_next;
      oe_reg         <= oe_next;
      busy_reg       <= busy_next;
      underrun_reg   <= underrun_next;
    end
  end

  assign tx_to_ready = ready;
  assign tx_dp       = dp_reg;
  assign tx_dm       = dm_reg;
  assign tx_oe       = oe_reg;
  assign tx_busy     = busy_reg;
  assign tx_underrun = underrun_reg;

endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
- Downstream stage of the TX token/handshake packet builder. Accepts its byte stream over a sop/eop/valid/ready handshake.
- Adds SYNC, sends each byte LSB-first with USB bit stuffing and NRZI encoding, then adds EOP (SE0, SE0, J).
- Drives full-speed line states (dp/dm/oe) toward the transceiver, one bit per bit_en pulse.

Parameters:
- SYNC_PATTERN, 8'h80, SYNC byte sent LSB-first: bits 0,0,0,0,0,0,0,1.
- STUFF_LEN, 6, number of consecutive 1s after which a 0 is inserted.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- bit_en  input  1  bit-time strobe (e.g. 12 MHz rate in a 48 MHz clk); one line bit per pulse
- tx_to_sop  input  1  current byte is first of packet
- tx_to_eop  input  1  current byte is last of packet
- tx_to_valid  input  1  byte available
- tx_to_ready  output  1  byte accepted when valid && ready
- tx_to_data  input  8  packet byte (PID byte first)
- tx_dp  output  1  D+ drive level
- tx_dm  output  1  D- drive level
- tx_oe  output  1  transceiver output enable
- tx_busy  output  1  packet in progress (SYNC through final J)
- tx_underrun  output  1  one-clk pulse: byte starvation mid-packet

Behaviour:
- One clock; rst is synchronous and active-high.
- Reset values: tx_dp=1, tx_dm=0 (J), tx_oe=0, tx_busy=0, tx_underrun=0, tx_to_ready=1, holding buffer empty, FSM=IDLE, ones_cnt=0.
- Storage: one holding register (data + eop flag) and one 8-bit shift register with a 3-bit bit index.
- tx_to_ready = holding buffer empty && FSM not in EOP_SE0/EOP_J. A transfer (valid && ready) loads the buffer on that clk.
- In IDLE, a transfer with sop=0 is accepted and discarded; the FSM stays IDLE.
- All line-state changes, bit counters and FSM transitions occur only on clk edges where bit_en=1. Outputs hold between pulses.
- FSM:
  - IDLE: on the first bit_en with buffer valid (sop byte) -> SYNC. Set tx_oe=1, tx_busy=1. Drive the first SYNC bit on that same bit_en.
  - SYNC: 8 bit times of SYNC_PATTERN. On its last bit, move the buffer to the shift register (buffer freed) -> DATA.
  - DATA: each bit_en emits either a stuff 0 (does not advance index) or the next data bit. After bit 7:
    - if the current byte had eop: -> EOP_SE0, unless a stuff bit is pending; a pending stuff bit is emitted first.
    - else if buffer valid: load the next byte.
    - else: underrun -> pulse tx_underrun, -> EOP_SE0.
  - EOP_SE0: 2 bit times, tx_dp=0, tx_dm=0 -> EOP_J.
  - EOP_J: 1 bit time J (dp=1, dm=0). Then on the next bit_en go to IDLE with tx_oe=0, tx_busy=0.
- Bit stuffing:
  - ones_cnt counts consecutive transmitted 1s, including SYNC's final 1 (ones_cnt=1 on entering DATA).
  - On reaching STUFF_LEN, the next bit slot is a 0 and ones_cnt clears.
  - Any transmitted 0 clears ones_cnt. The counter saturates at STUFF_LEN.
- NRZI: a 0 bit toggles J<->K; a 1 bit holds the line. K = dp0/dm1. The first SYNC bit toggles from idle J to K.
- Latency: first line bit at the first bit_en after the sop byte is registered. Byte n+1 may be accepted as soon as byte n moves to the shift register.
- rst mid-packet: immediate return to reset values on that clk; no EOP is sent.

Test Plan:
- ACK: one byte 0xD2, sop=1, eop=1 -> line states KJKJKJKK, JJKJJKKK, SE0, SE0, J (19 bit times), then tx_oe=0, tx_busy=0. tx_to_ready returns to 1 at the end of SYNC.
- Token: bytes 0x69, 0x3A, 0x0B (last with eop), fed back-to-back -> no ready stall beyond one byte; 8+24+3 bit times, no stuffing; tx_underrun stays 0.
- Stuffing: 0xFF (sop) then 0xFF (eop) -> stuff 0s after data bits 5 and 11; 29 bit times total; each stuff bit toggles the line.
- Underrun: sop byte 0x2D without eop, then valid held low -> after its 8th data bit, tx_underrun pulses for 1 clk, followed by SE0, SE0, J.
- bit_en gaps: bit_en every 4 clks with random extra gaps -> line state constant between strobes; same bit sequence as the ACK test.
- Reset at bit 12 of a token -> next clk: dp=1, dm=0, oe=0, ready=1. A new ACK afterwards is sent correctly.
